// File: rtl/wb_gain_calc_if.sv
// Statistics handshake bundle between the stats accumulator and wb_gain_calc.
// The master drives valid and the per-channel sums (ch0 in the LSBs); the slave returns ready.
interface wb_gain_calc_if #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned SUM_WIDTH = 32
);
    logic                          stat_valid_i;
    logic [CHANNELS*SUM_WIDTH-1:0] stat_sum_i;
    logic                          stat_ready_o;

    modport master (output stat_valid_i, output stat_sum_i, input stat_ready_o);
    modport slave  (input stat_valid_i, input stat_sum_i, output stat_ready_o);
endinterface

// File: rtl/wb_gain_calc.sv
// White-balance gain controller: gray-world gains via a serial restoring divider,
// manual shadow coefficients, and frame-boundary application of new gains.
// Optional feature macro: WB_GAIN_CLAMP_EN clamps computed and manual gains to MAX_GAIN.
module wb_gain_calc #(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned SUM_WIDTH  = 32,
    parameter int unsigned COEF_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned REF_CH     = 1,
    parameter logic [COEF_WIDTH-1:0] MAX_GAIN = 32'h0004_0000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [1:0]                     mode_i,
    input  logic                           cal_stb_i,
    input  logic [$clog2(CHANNELS)-1:0]    man_sel_i,
    input  logic [COEF_WIDTH-1:0]          man_coef_i,
    input  logic                           man_lock_i,
    output logic [COEF_WIDTH-1:0]          cur_coef_o,
    wb_gain_calc_if.slave                  stat,
    input  logic                           frame_start_i,
    output logic [CHANNELS*COEF_WIDTH-1:0] coef_o,
    output logic                           busy_o
);
    localparam int unsigned N     = SUM_WIDTH + FRAC_BITS;
    localparam int unsigned SEL_W = $clog2(CHANNELS);
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [COEF_WIDTH-1:0] UNITY = COEF_WIDTH'(1) << FRAC_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_STORE, S_DONE} state_t;

    state_t state_q, state_d;
    logic   accept_c, start_c;

    logic [CHANNELS-1:0][SUM_WIDTH-1:0]  sums_q;
    logic [CHANNELS-1:0][COEF_WIDTH-1:0] results_q, pending_q, shadow_q, coef_q;
    logic [N-1:0]          dq_q;
    logic [SUM_WIDTH-1:0]  rem_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SEL_W-1:0]      ch_q;
    logic                  pending_vld_q, armed_q, lock_d_q, ready_q, busy_q;
    logic [COEF_WIDTH-1:0] cur_q;

    logic [SUM_WIDTH-1:0]  divisor_c, sub_c;
    logic [SUM_WIDTH:0]    rem_sh_c;
    logic                  ge_c, ovf_c;
    logic [COEF_WIDTH-1:0] result_c;

    // Ceiling applied to computed gains and manual writes when clamping is built in.
    function automatic logic [COEF_WIDTH-1:0] clamp_gain(input logic [COEF_WIDTH-1:0] g);
`ifdef WB_GAIN_CLAMP_EN
        return (g > MAX_GAIN) ? MAX_GAIN : g;
`else
        return g;
`endif
    endfunction

`ifndef WB_GAIN_CLAMP_EN
    // MAX_GAIN only matters when clamping is built in.
    logic unused_max_gain;
    assign unused_max_gain = ^MAX_GAIN;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and handshake decode.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        start_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept_c = stat.stat_valid_i;
                start_c  = accept_c && ((mode_i == 2'd3) || ((mode_i == 2'd2) && armed_q));
                if (start_c) state_d = S_LOAD;
            end
            S_LOAD:  state_d = S_DIV;
            S_DIV:   if (cnt_q == CNT_W'(N - 1)) state_d = S_STORE;
            S_STORE: state_d = (ch_q == SEL_W'(CHANNELS - 1)) ? S_DONE : S_DIV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider step, divisor select and quotient saturation.
    always_comb begin
        divisor_c = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (ch_q == SEL_W'(c)) divisor_c = sums_q[c];
        rem_sh_c = {rem_q, dq_q[N-1]};
        ge_c     = rem_sh_c >= {1'b0, divisor_c};
        sub_c    = SUM_WIDTH'(rem_sh_c - {1'b0, divisor_c});
        ovf_c    = |(dq_q >> COEF_WIDTH);
        result_c = (divisor_c == '0 || ovf_c) ? '1 : COEF_WIDTH'(dq_q);
        result_c = clamp_gain(result_c);
    end

    // Sum capture and serial restoring division, one quotient bit per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sums_q    <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            results_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_c) sums_q <= stat.stat_sum_i;
                S_LOAD: begin
                    dq_q  <= N'(sums_q[REF_CH]) << FRAC_BITS;
                    rem_q <= '0;
                    cnt_q <= '0;
                    ch_q  <= '0;
                end
                S_DIV: begin
                    dq_q  <= {dq_q[N-2:0], ge_c};
                    rem_q <= ge_c ? sub_c : SUM_WIDTH'(rem_sh_c);
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_STORE: begin
                    for (int c = 0; c < CHANNELS; c++)
                        if (ch_q == SEL_W'(c)) results_q[c] <= result_c;
                    dq_q  <= N'(sums_q[REF_CH]) << FRAC_BITS;
                    rem_q <= '0;
                    cnt_q <= '0;
                    ch_q  <= ch_q + SEL_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Pending gains and frame-boundary update of the active coefficients.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_q        <= {CHANNELS{UNITY}};
            pending_q     <= {CHANNELS{UNITY}};
            pending_vld_q <= 1'b0;
        end else begin
            if (frame_start_i) begin
                case (mode_i)
                    2'd0:    coef_q <= {CHANNELS{UNITY}};
                    2'd1:    coef_q <= shadow_q;
                    default: if (pending_vld_q) begin
                        coef_q        <= pending_q;
                        pending_vld_q <= 1'b0;
                    end
                endcase
            end
            // A completion in the same cycle as frame_start wins the valid flag.
            if (state_q == S_DONE && mode_i[1]) begin
                pending_q     <= results_q;
                pending_vld_q <= 1'b1;
            end
        end
    end

    // Manual shadow writes, calibration arming and coefficient readback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= {CHANNELS{UNITY}};
            lock_d_q <= 1'b0;
            armed_q  <= 1'b0;
            cur_q    <= UNITY;
        end else begin
            lock_d_q <= man_lock_i;
            if (man_lock_i && !lock_d_q)
                for (int c = 0; c < CHANNELS; c++)
                    if (man_sel_i == SEL_W'(c)) shadow_q[c] <= clamp_gain(man_coef_i);
            if (accept_c)                      armed_q <= 1'b0;
            if (cal_stb_i && mode_i == 2'd2)   armed_q <= 1'b1;
            cur_q <= '0;
            for (int c = 0; c < CHANNELS; c++)
                if (man_sel_i == SEL_W'(c)) cur_q <= coef_q[c];
        end
    end

    // Registered status flags tracking the upcoming state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign stat.stat_ready_o = ready_q;
    assign busy_o            = busy_q;
    assign coef_o            = coef_q;
    assign cur_coef_o        = cur_q;
endmodule

// File: tb/tb_wb_gain_calc.sv
// Scoreboard bench for wb_gain_calc: expected coef_o vectors are queued at each frame_start
// and checked by an independent monitor; status outputs are checked directly.
module tb_wb_gain_calc;
    localparam int unsigned CH = 3;
    localparam int unsigned SW = 32;
    localparam int unsigned CW = 32;
    typedef logic [CH*CW-1:0] coefv_t;

    localparam logic [CW-1:0] U = 32'h0001_0000;
    localparam coefv_t UNITY3 = {U, U, U};
`ifdef WB_GAIN_CLAMP_EN
    localparam logic [CW-1:0] ZDIV = 32'h0004_0000;
`else
    localparam logic [CW-1:0] ZDIV = 32'hFFFF_FFFF;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          cal_stb;
    logic [1:0]    man_sel;
    logic [CW-1:0] man_coef;
    logic          man_lock;
    logic [CW-1:0] cur_coef;
    logic          frame_start;
    coefv_t        coef;
    logic          busy;

    wb_gain_calc_if #(.CHANNELS(CH), .SUM_WIDTH(SW)) sif ();

    wb_gain_calc dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .cal_stb_i(cal_stb),
        .man_sel_i(man_sel), .man_coef_i(man_coef), .man_lock_i(man_lock),
        .cur_coef_o(cur_coef), .stat(sif), .frame_start_i(frame_start),
        .coef_o(coef), .busy_o(busy)
    );

    always #5 clk = ~clk;

    coefv_t exp_q[$];
    coefv_t exp_v;
    coefv_t last_coef;
    int     n_vec = 0;
    int     n_err = 0;
    logic   fs_d  = 1'b0;
    logic   rst_d = 1'b1;

    always @(posedge clk) begin
        fs_d  <= frame_start;
        rst_d <= rst;
    end

    // Monitor: compare coef_o after each frame boundary, flag changes anywhere else.
    always @(negedge clk) begin
        if (fs_d) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL coef_o unexpected frame boundary, got %h", coef);
            end else begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if (coef !== exp_v) begin
                    n_err++;
                    $display("FAIL coef_o at frame %0d: got %h want %h", n_vec, coef, exp_v);
                end
            end
        end else if (!rst_d && coef !== last_coef) begin
            n_err++;
            $display("FAIL coef_o changed off frame boundary: got %h was %h", coef, last_coef);
        end
        last_coef = coef;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CH*CW-1:0] got, input logic [CH*CW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic frame(input coefv_t e);
        exp_q.push_back(e);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Present one statistics transfer and hold it until accepted (bounded).
    task automatic send(input logic [SW-1:0] r, input logic [SW-1:0] g, input logic [SW-1:0] b);
        sif.stat_sum_i   = {b, g, r};
        sif.stat_valid_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (sif.stat_ready_o) begin
                tick(1);
                sif.stat_valid_i = 1'b0;
                return;
            end
            tick(1);
        end
        sif.stat_valid_i = 1'b0;
        n_vec++;
        n_err++;
        $display("FAIL send timeout: stat_ready_o stayed %b", sif.stat_ready_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = 2'd3; cal_stb = 1'b0; man_sel = 2'd0; man_coef = '0;
        man_lock = 1'b0; frame_start = 1'b0;
        sif.stat_valid_i = 1'b0; sif.stat_sum_i = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        chk("rst_ready", 96'(sif.stat_ready_o), 96'(1));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_coef", coef, UNITY3);
        chk("rst_cur_coef", 96'(cur_coef), 96'(U));

        // Mode 3 nominal: hold mid-calc, frame at DONE still old, next frame applies
        send(32'h1000, 32'h2000, 32'h4000);
        chk("m3_busy_start", 96'(busy), 96'(1));
        chk("m3_ready_start", 96'(sif.stat_ready_o), 96'(0));
        tick(50);
        frame(UNITY3);
        tick(97);
        chk("m3_busy_last", 96'(busy), 96'(1));
        frame(UNITY3);
        chk("m3_busy_done", 96'(busy), 96'(0));
        chk("m3_ready_done", 96'(sif.stat_ready_o), 96'(1));
        frame({32'h0000_8000, 32'h0001_0000, 32'h0002_0000});

        // Mode 3, zero red sum
        send(32'h0, 32'h2000, 32'h4000);
        tick(150);
        frame({32'h0000_8000, 32'h0001_0000, ZDIV});

        // Mode 2: unarmed transfer dropped, armed transfer computes once
        mode = 2'd2;
        send(32'h3000, 32'h3000, 32'h1800);
        chk("m2_drop_busy", 96'(busy), 96'(0));
        frame({32'h0000_8000, 32'h0001_0000, ZDIV});
        cal_stb = 1'b1;
        tick(1);
        cal_stb = 1'b0;
        send(32'h3000, 32'h3000, 32'h1800);
        chk("m2_armed_busy", 96'(busy), 96'(1));
        tick(150);
        frame({32'h0002_0000, 32'h0001_0000, 32'h0001_0000});
        send(32'h3000, 32'h3000, 32'h1800);
        chk("m2_disarmed_busy", 96'(busy), 96'(0));

        // Mode 1: shadow write on lock edge only, applied at frame_start
        mode = 2'd1;
        man_sel = 2'd2; man_coef = 32'h0001_8000; man_lock = 1'b1;
        tick(2);
        man_coef = 32'h0000_7777;
        tick(2);
        chk("m1_cur_before", 96'(cur_coef), 96'(32'h0002_0000));
        frame({32'h0001_8000, U, U});
        tick(1);
        chk("m1_cur_after", 96'(cur_coef), 96'(32'h0001_8000));
        man_sel = 2'd3;
        tick(2);
        chk("m1_cur_oob", 96'(cur_coef), 96'(0));
        man_lock = 1'b0;

        // Reset mid-calculation
        mode = 2'd3; man_sel = 2'd0;
        send(32'h1000, 32'h2000, 32'h4000);
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_busy", 96'(busy), 96'(0));
        chk("rst_mid_ready", 96'(sif.stat_ready_o), 96'(1));
        chk("rst_mid_coef", coef, UNITY3);
        tick(150);
        frame(UNITY3);

        // Mode switch 3->0 mid-calc discards results
        mode = 2'd1; man_coef = 32'h0000_5000; man_lock = 1'b1;
        tick(2);
        man_lock = 1'b0;
        frame({U, U, 32'h0000_5000});
        mode = 2'd3;
        send(32'h1000, 32'h2000, 32'h4000);
        tick(60);
        mode = 2'd0;
        tick(100);
        chk("sw_busy", 96'(busy), 96'(0));
        frame(UNITY3);
        mode = 2'd3;
        tick(1);
        frame(UNITY3);

        tick(3);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
